dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache with its refill/write controller, sitting directly downstream of the decode/control stage in the pipelined core. It consumes the `MemLD`/`MemWE` strobes plus the ALU-computed address and store data from the MEM stage. It returns load data and drives the `stall` that freezes the pipeline, including the control stage's flush state register. Misses and all stores go to a word-wide request/acknowledge memory port.

---
 rtl/dcache_ctrl_if.sv | 20 ++
 rtl/dcache_ctrl.sv | 125 ++++++++++++
 tb/tb_dcache_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// Word-wide request/acknowledge memory port between the data cache and
// the memory system. The cache is the master; memory is the slave.
interface dcache_ctrl_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  modport master (
    output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
    input  MEM_RDATA, MEM_ACK
  );

  modport slave (
    input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
    output MEM_RDATA, MEM_ACK
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with its
// refill/write controller. Loads hit with zero stall; misses refill a
// 4-word line one word at a time; every store is written through to memory.
module dcache_ctrl #(
  parameter int LINES = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          MemLD,
  input  logic          MemWE,
  input  logic [31:0]   ADDR,
  input  logic [31:0]   WDATA,
  output logic [31:0]   RDATA,
  output logic          stall,
  dcache_ctrl_if.master mem
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [LINES-1:0] valid;
  logic [TW-1:0] tag_mem  [LINES];
  logic [31:0]   data_mem [LINES][4];

  logic [1:0]    offset;
  logic [IW-1:0] index;
  logic [TW-1:0] tag;
  logic          hit;
  logic          unused_addr;

  assign offset      = ADDR[3:2];
  assign index       = ADDR[3+IW:4];
  assign tag         = ADDR[31:4+IW];
  assign hit         = valid[index] && (tag_mem[index] == tag);
  // Byte offset within a word is meaningless for word-only accesses.
  assign unused_addr = ^ADDR[1:0];

  // Load data straight from the array; forced to zero while in reset.
  assign RDATA = RST ? 32'd0 : data_mem[index][offset];

  // Controller state, word counter and valid bits.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= 2'd0;
      valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemWE) begin
            state <= WRITE;
          end else if (MemLD && !hit) begin
            state        <= FILL;
            cnt          <= 2'd0;
            valid[index] <= 1'b0;
          end
        end
        FILL: begin
          if (mem.MEM_ACK) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              valid[index] <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        WRITE: begin
          if (mem.MEM_ACK) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays: store-hit update and line refill.
  // NOTE: the arrays carry no reset; the valid bits alone decide whether
  // their contents mean anything, and resetting RAMs defeats RAM inference.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == IDLE && MemWE && hit) begin
        data_mem[index][offset] <= WDATA;
      end
      if (state == FILL && mem.MEM_ACK) begin
        data_mem[index][cnt] <= mem.MEM_RDATA;
        if (cnt == 2'd3) tag_mem[index] <= tag;
      end
    end
  end

  // Stall and memory-port outputs decoded from state; all idle in reset.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    stall         = 1'b0;
    mem.MEM_REQ   = 1'b0;
    mem.MEM_WE    = 1'b0;
    mem.MEM_ADDR  = 32'd0;
    mem.MEM_WDATA = 32'd0;
    if (!RST) begin
      case (state)
        IDLE: stall = MemWE || (MemLD && !hit);
        FILL: begin
          stall        = 1'b1;
          mem.MEM_REQ  = 1'b1;
          mem.MEM_ADDR = {ADDR[31:4], cnt, 2'b00};
        end
        WRITE: begin
          stall         = 1'b1;
          mem.MEM_REQ   = 1'b1;
          mem.MEM_WE    = 1'b1;
          mem.MEM_ADDR  = {ADDR[31:2], 2'b00};
          mem.MEM_WDATA = WDATA;
        end
        default: stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: cold miss, hit, store hit,
// conflict, store miss, slow memory, reset mid-fill and dual strobe.
module tb_dcache_ctrl;

  logic        CLK;
  logic        RST;
  logic        MemLD;
  logic        MemWE;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        stall;

  dcache_ctrl_if mem_bus ();

  dcache_ctrl #(.LINES(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .MemLD (MemLD),
    .MemWE (MemWE),
    .ADDR  (ADDR),
    .WDATA (WDATA),
    .RDATA (RDATA),
    .stall (stall),
    .mem   (mem_bus.master)
  );

  logic [31:0] mem_words [0:1023];
  int n_cmp = 0;
  int n_err = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load that must miss; the bench plays memory with 'dly' cycles per ack.
  task automatic load_miss(input logic [31:0] a, input int dly, input logic [31:0] exp);
    int sc;
    logic [31:0] ea;
    sc = 0;
    @(negedge CLK);
    MemWE = 1'b0; MemLD = 1'b1; ADDR = a; mem_bus.MEM_ACK = 1'b0;
    #1;
    check("miss_detect_stall", {31'd0, stall}, 32'd1);
    check("miss_detect_req", {31'd0, mem_bus.MEM_REQ}, 32'd0);
    if (stall) sc++;
    for (int w = 0; w < 4; w++) begin
      ea = {a[31:4], w[1:0], 2'b00};
      for (int k = 0; k < dly; k++) begin
        @(negedge CLK);
        mem_bus.MEM_ACK = 1'b0;
        #1;
        check("fill_req", {31'd0, mem_bus.MEM_REQ}, 32'd1);
        check("fill_we", {31'd0, mem_bus.MEM_WE}, 32'd0);
        check("fill_addr", mem_bus.MEM_ADDR, ea);
        if (stall) sc++;
        if (k == dly - 1) begin
          mem_bus.MEM_ACK   = 1'b1;
          mem_bus.MEM_RDATA = mem_words[ea[11:2]];
        end
      end
    end
    @(negedge CLK);
    mem_bus.MEM_ACK = 1'b0;
    #1;
    check("miss_replay_stall", {31'd0, stall}, 32'd0);
    check("miss_replay_rdata", RDATA, exp);
    check("miss_replay_req", {31'd0, mem_bus.MEM_REQ}, 32'd0);
    check("miss_stall_cycles", sc, 1 + 4 * dly);
  endtask

  // Load that must hit in the same cycle.
  task automatic load_hit(input logic [31:0] a, input logic [31:0] exp);
    @(negedge CLK);
    MemWE = 1'b0; MemLD = 1'b1; ADDR = a;
    #1;
    check("hit_stall", {31'd0, stall}, 32'd0);
    check("hit_rdata", RDATA, exp);
    check("hit_req", {31'd0, mem_bus.MEM_REQ}, 32'd0);
  endtask

  // Store (optionally with MemLD also high); memory acks after 'dly' cycles.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input int dly, input logic both);
    int sc;
    sc = 0;
    @(negedge CLK);
    MemLD = both; MemWE = 1'b1; ADDR = a; WDATA = d; mem_bus.MEM_ACK = 1'b0;
    #1;
    check("st_detect_stall", {31'd0, stall}, 32'd1);
    check("st_detect_req", {31'd0, mem_bus.MEM_REQ}, 32'd0);
    if (stall) sc++;
    for (int k = 0; k < dly; k++) begin
      @(negedge CLK);
      mem_bus.MEM_ACK = 1'b0;
      #1;
      check("st_req", {31'd0, mem_bus.MEM_REQ}, 32'd1);
      check("st_we", {31'd0, mem_bus.MEM_WE}, 32'd1);
      check("st_addr", mem_bus.MEM_ADDR, {a[31:2], 2'b00});
      check("st_wdata", mem_bus.MEM_WDATA, d);
      if (stall) sc++;
      if (k == dly - 1) begin
        mem_bus.MEM_ACK = 1'b1;
        mem_words[a[11:2]] = d;
      end
    end
    @(negedge CLK);
    mem_bus.MEM_ACK = 1'b0;
    #1;
    check("st_done_stall", {31'd0, stall}, 32'd0);
    check("st_done_req", {31'd0, mem_bus.MEM_REQ}, 32'd0);
    check("st_done_addr", mem_bus.MEM_ADDR, 32'd0);
    check("st_stall_cycles", sc, 1 + dly);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem_words[i] = 32'd0;
    mem_words[32'h100 >> 2] = 32'hA0; mem_words[32'h104 >> 2] = 32'hA1;
    mem_words[32'h108 >> 2] = 32'hA2; mem_words[32'h10C >> 2] = 32'hA3;
    mem_words[32'h180 >> 2] = 32'hB0; mem_words[32'h184 >> 2] = 32'hB1;
    mem_words[32'h188 >> 2] = 32'hB2; mem_words[32'h18C >> 2] = 32'hB3;
    mem_words[32'h200 >> 2] = 32'h60; mem_words[32'h204 >> 2] = 32'h61;
    mem_words[32'h208 >> 2] = 32'h62; mem_words[32'h20C >> 2] = 32'h63;
    mem_words[32'h240 >> 2] = 32'hC0; mem_words[32'h244 >> 2] = 32'hC1;
    mem_words[32'h248 >> 2] = 32'hC2; mem_words[32'h24C >> 2] = 32'hC3;

    RST = 1'b1; MemLD = 1'b0; MemWE = 1'b0; ADDR = 32'd0; WDATA = 32'd0;
    mem_bus.MEM_ACK = 1'b0; mem_bus.MEM_RDATA = 32'd0;

    // Reset: outputs idle even with a request presented.
    @(negedge CLK);
    MemLD = 1'b1; ADDR = 32'h100;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, mem_bus.MEM_REQ}, 32'd0);
    check("rst_we", {31'd0, mem_bus.MEM_WE}, 32'd0);
    check("rst_addr", mem_bus.MEM_ADDR, 32'd0);
    check("rst_wdata", mem_bus.MEM_WDATA, 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    @(negedge CLK);
    RST = 1'b0; MemLD = 1'b0;
    #1;
    check("idle_stall", {31'd0, stall}, 32'd0);

    // 1. Cold load miss, 2. load hit.
    load_miss(32'h100, 1, 32'hA0);
    load_hit(32'h108, 32'hA2);

    // 3. Store hit, then read it back.
    store(32'h104, 32'hDEADBEEF, 1, 1'b0);
    load_hit(32'h104, 32'hDEADBEEF);

    // 4. Conflict on index 0, then store miss without allocation.
    load_miss(32'h180, 1, 32'hB0);
    load_hit(32'h18C, 32'hB3);
    load_miss(32'h100, 1, 32'hA0);
    load_hit(32'h104, 32'hDEADBEEF);
    store(32'h200, 32'h5555AAAA, 1, 1'b0);
    load_miss(32'h200, 1, 32'h5555AAAA);

    // 5. Slow memory: 3 cycles per word on index 4.
    load_miss(32'h248, 3, 32'hC2);
    load_hit(32'h240, 32'hC0);

    // 6a. Reset after two of four fill acks on line 0x100.
    @(negedge CLK);
    MemWE = 1'b0; MemLD = 1'b1; ADDR = 32'h100;
    #1;
    check("pf_detect_stall", {31'd0, stall}, 32'd1);
    for (int w = 0; w < 2; w++) begin
      @(negedge CLK);
      #1;
      check("pf_addr", mem_bus.MEM_ADDR, 32'h100 + 32'(w * 4));
      mem_bus.MEM_ACK   = 1'b1;
      mem_bus.MEM_RDATA = mem_words[(32'h100 >> 2) + w];
    end
    @(negedge CLK);
    mem_bus.MEM_ACK = 1'b0; RST = 1'b1;
    #1;
    check("pf_rst_stall", {31'd0, stall}, 32'd0);
    check("pf_rst_req", {31'd0, mem_bus.MEM_REQ}, 32'd0);
    check("pf_rst_addr", mem_bus.MEM_ADDR, 32'd0);
    @(negedge CLK);
    RST = 1'b0; MemLD = 1'b0;
    load_miss(32'h10C, 1, 32'hA3);
    load_hit(32'h104, 32'hDEADBEEF);

    // 6b. Dual strobe is a store.
    store(32'h104, 32'h12345678, 1, 1'b1);
    load_hit(32'h104, 32'h12345678);

    // Stray ack while idle has no effect.
    @(negedge CLK);
    MemLD = 1'b0; MemWE = 1'b0; mem_bus.MEM_ACK = 1'b1;
    #1;
    check("stray_ack_req", {31'd0, mem_bus.MEM_REQ}, 32'd0);
    check("stray_ack_stall", {31'd0, stall}, 32'd0);
    @(negedge CLK);
    mem_bus.MEM_ACK = 1'b0;
    load_hit(32'h108, 32'hA2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
